// File: rtl/t08_mem_pkg.sv
// Shared types and constants for the t08 single-port memory controller.
// Holds the FSM state enum, func3 codes, error causes and the NOP word.
package t08_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FETCH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store widths share the low func3 bits with the loads.
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Halves may not straddle a word; words must sit on a word boundary.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        logic half;
        half = (f3 == F3_LH) || (f3 == F3_LHU);
        return (half && off == 2'd3) || (f3 == F3_LW && off != 2'd0);
    endfunction

endpackage

// File: rtl/t08_mem_port_ctrl_load_align.sv
// Load lane select and sign/zero extension.
// Ports: rdata_i bus word, off_i byte offset, func3_i width code, data_o result.
module t08_load_align
    import t08_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = rdata_i[{off_i, 3'b000} +: 8];
        half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = rdata_i;
        case (func3_i)
            F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data_o = {24'h0, byte_s};
            F3_LH:   data_o = {{16{half_s[15]}}, half_s};
            F3_LHU:  data_o = {16'h0, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/t08_mem_port_ctrl.sv
// Single-port memory controller: serialises fetches and loads/stores onto
// one bus port with lane alignment, MMIO completion, error and stall reporting.
// Ports: core side (fetch_pc, data_addr, wdata, rd_en, wr_en, func3 ->
// instr, load_data, freeze, err), bus side (mem_* strobes/data/response).
module t08_mem_port_ctrl
    import t08_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RAM_LIMIT   = 2048,
    parameter int unsigned MMIO_BASE   = 923923,
    parameter int unsigned MMIO_WORDS  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       wdata,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              freeze,
    output logic              err,
    output logic [1:0]        err_cause
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(RAM_LIMIT);
    localparam logic [ADDR_W-1:0] MMIO_LO = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] MMIO_HI =
        ADDR_W'(MMIO_BASE + 4 * MMIO_WORDS);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic              wr_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic [31:0]       load_data_q;
    logic              load_valid_q;
    logic              err_q;
    err_e              err_cause_q;

    logic [1:0]  off_s;
    logic        is_mmio_s;
    logic        data_ok_s;
    logic        tmo_s;
    logic [31:0] fmt_s;

    assign off_s = addr_q[1:0];
    assign is_mmio_s = (addr_q >= RAM_TOP) &&
                       (addr_q >= MMIO_LO) && (addr_q < MMIO_HI);
    // mem_done only matters inside the MMIO window.
    assign data_ok_s = !mem_busy && (!is_mmio_s || mem_done);
    assign tmo_s = (cnt_q == CNT_LAST);

    t08_load_align u_align (
        .rdata_i (mem_rdata),
        .off_i   (off_s),
        .func3_i (f3_q),
        .data_o  (fmt_s)
    );

    // Gated by nrst so an access in flight drops the moment reset asserts.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (nrst) begin
            case (state_q)
                S_DATA: begin
                    mem_addr = addr_q;
                    mem_addr[1:0] = 2'b00;
                    if (wr_q) begin
                        mem_write = 1'b1;
                        case (f3_q[1:0])
                            W_BYTE: begin
                                mem_be    = 4'b0001 << off_s;
                                mem_wdata = {4{wdata_q[7:0]}};
                            end
                            W_HALF: begin
                                mem_be    = off_s[1] ? 4'b1100 : 4'b0011;
                                mem_wdata = {2{wdata_q[15:0]}};
                            end
                            default: begin
                                mem_be    = 4'b1111;
                                mem_wdata = wdata_q;
                            end
                        endcase
                    end else begin
                        mem_read = 1'b1;
                        mem_be   = 4'b1111;
                    end
                end
                S_FETCH: begin
                    mem_addr = fetch_pc;
                    mem_addr[1:0] = 2'b00;
                    mem_read = 1'b1;
                    mem_be   = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_FETCH;
            addr_q        <= '0;
            wdata_q       <= '0;
            f3_q          <= '0;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            load_data_q   <= '0;
            load_valid_q  <= 1'b0;
            err_q         <= 1'b0;
            err_cause_q   <= ERR_NONE;
        end else begin
            instr_valid_q <= 1'b0;
            load_valid_q  <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    state_q <= S_FETCH;
                    if (rd_en || wr_en) begin
                        addr_q  <= data_addr;
                        wdata_q <= wdata;
                        f3_q    <= func3;
                        wr_q    <= wr_en;
                        if (misaligned(func3, data_addr[1:0])) begin
                            err_q       <= 1'b1;
                            err_cause_q <= ERR_MISALIGN;
                            if (!wr_en) begin
                                load_data_q  <= '0;
                                load_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_ok_s) begin
                        if (!wr_q) begin
                            load_data_q  <= fmt_s;
                            load_valid_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end else if (tmo_s) begin
                        err_q       <= 1'b1;
                        err_cause_q <= ERR_TIMEOUT;
                        if (!wr_q) begin
                            load_data_q  <= '0;
                            load_valid_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!mem_busy) begin
                        instr_q       <= mem_rdata;
                        instr_valid_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= S_IDLE;
                    end else if (tmo_s) begin
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b1;
                        err_q         <= 1'b1;
                        err_cause_q   <= ERR_TIMEOUT;
                        cnt_q         <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign freeze      = (state_q != S_IDLE);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign err         = err_q;
    assign err_cause   = err_cause_q;

endmodule
